// File: rtl/lcd_mode_sequencer.sv
// lcd_mode_sequencer
// Runs the HD44780 power-up initialisation on an 8-bit write-only LCD bus,
// then turns each change of the 2-bit operation-mode word into a single
// display-control command. All enable-pulse and command-wait timing is
// generated here; the LCD busy flag is never read.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   mode      operation mode from the PIO out_port
//   lcd_data  LCD DB7..DB0 (registered)
//   lcd_rs    register select, always 0 (commands only)
//   lcd_rw    read/write, tied 0 (write)
//   lcd_en    LCD enable strobe (registered)
//   busy      high during power-up, init or a command in progress
//   cmd_done  one-cycle pulse when a mode command's wait completes
module lcd_mode_sequencer #(
  parameter int unsigned POWERUP_CYCLES    = 750000,
  parameter int unsigned SETUP_CYCLES      = 2,
  parameter int unsigned EN_HIGH_CYCLES    = 12,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       busy,
  output logic       cmd_done
);

  localparam int unsigned MAX_AB  = (POWERUP_CYCLES > SETUP_CYCLES) ? POWERUP_CYCLES : SETUP_CYCLES;
  localparam int unsigned MAX_ABC = (MAX_AB > EN_HIGH_CYCLES) ? MAX_AB : EN_HIGH_CYCLES;
  localparam int unsigned MAX_ABCD = (MAX_ABC > CMD_WAIT_CYCLES) ? MAX_ABC : CMD_WAIT_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_ABCD > CLEAR_WAIT_CYCLES) ? MAX_ABCD : CLEAR_WAIT_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;

  // Terminal counts: each phase counts 0 .. N-1, so the counter never wraps.
  localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST      = CNT_W'(EN_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LAST     = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_WAIT_CYCLES - 1);

  localparam logic [7:0] CMD_CLEAR = 8'h01;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_SETUP,
    ST_EN_HIGH,
    ST_WAIT,
    ST_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic [1:0]       idx_q, idx_d;
  logic             in_init_q, in_init_d;
  logic [1:0]       cmd_mode_q, cmd_mode_d;
  logic [1:0]       applied_q, applied_d;
  logic [CNT_W-1:0] wait_last;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = 8'h38;  // 8-bit bus, 2 lines
      2'd1:    c = 8'h0C;  // display on, cursor off
      2'd2:    c = 8'h01;  // clear
      default: c = 8'h06;  // entry mode increment
    endcase
    return c;
  endfunction

  function automatic logic [7:0] mode_cmd(input logic [1:0] m);
    logic [7:0] c;
    case (m)
      2'd0:    c = 8'h08;  // display off
      2'd1:    c = 8'h0C;  // display on
      2'd2:    c = 8'h0E;  // cursor on
      default: c = 8'h0F;  // cursor blink
    endcase
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    data_d     = data_q;
    en_d       = en_q;
    done_d     = 1'b0;
    idx_d      = idx_q;
    in_init_d  = in_init_q;
    cmd_mode_d = cmd_mode_q;
    applied_d  = applied_q;
    // The clear command needs the long wait; data_q still holds the command.
    wait_last  = (data_q == CMD_CLEAR) ? CLEAR_LAST : CMD_LAST;

    case (state_q)
      ST_POWERUP: begin
        if (cnt_q == POWERUP_LAST) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          idx_d   = 2'd0;
          data_d  = init_cmd(2'd0);
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_EN_HIGH;
          cnt_d   = '0;
          en_d    = 1'b1;
        end
      end
      ST_EN_HIGH: begin
        if (cnt_q == EN_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          en_d    = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          if (in_init_q) begin
            if (idx_q != 2'd3) begin
              idx_d   = idx_q + 2'd1;
              data_d  = init_cmd(idx_q + 2'd1);
              state_d = ST_SETUP;
            end else begin
              in_init_d = 1'b0;
              state_d   = ST_IDLE;
            end
          end else begin
            done_d    = 1'b1;
            applied_d = cmd_mode_q;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        // Only the mode seen here is issued; changes made while busy are dropped.
        if (mode != applied_q) begin
          cmd_mode_d = mode;
          data_d     = mode_cmd(mode);
          state_d    = ST_SETUP;
        end
      end
      default: begin
        state_d = ST_POWERUP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_POWERUP;
      cnt_q      <= '0;
      data_q     <= '0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= 2'd0;
      in_init_q  <= 1'b1;
      cmd_mode_q <= 2'b01;
      applied_q  <= 2'b01;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      en_q       <= en_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      in_init_q  <= in_init_d;
      cmd_mode_q <= cmd_mode_d;
      applied_q  <= applied_d;
    end
  end

  assign lcd_data = data_q;
  assign lcd_rs   = 1'b0;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;
  assign busy     = (state_q != ST_IDLE);
  assign cmd_done = done_q;

endmodule
